// File: rtl/mul_issue_ctrl_taint.sv
// Request-side driver for a valid-only multiplier: FIFO-buffers operand pairs, issues one at a
// time, waits for done (or times out), and reports product plus latency with 1-bit taint shadows.
module mul_issue_ctrl_taint #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic                 cmd_valid_t,
  output logic                 cmd_ready,
  output logic                 cmd_ready_t,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic                 cmd_a_t,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic                 cmd_b_t,
  output logic                 mul_valid,
  output logic                 mul_valid_t,
  output logic [WIDTH-1:0]     mul_a,
  output logic                 mul_a_t,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_b_t,
  input  logic                 mul_done,
  input  logic                 mul_done_t,
  input  logic [2*WIDTH-1:0]   mul_result,
  input  logic                 mul_result_t,
  output logic                 res_valid,
  output logic                 res_valid_t,
  output logic [2*WIDTH-1:0]   res_data,
  output logic                 res_data_t,
  output logic [CNT_W-1:0]     res_cycles,
  output logic                 res_cycles_t,
  output logic                 timeout,
  output logic                 timeout_t
);
  // Handshake: an operand pair transfers on a cycle where cmd_valid && cmd_ready at the rising
  // edge; mul_valid, res_valid and timeout are single-cycle pulses with no back-pressure.

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t state_q, state_d;

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic             mem_at [DEPTH];
  logic             mem_bt [DEPTH];
  logic             full, empty, push, pop;
  logic [CNT_W-1:0] cnt_q;
  logic             tim_t, wd_t, occ_t;
  logic             at_limit;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign cmd_ready = !full;
  assign push  = cmd_valid && cmd_ready;
  assign pop   = (state_q == S_ISSUE);
  assign at_limit = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mul_done || at_limit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i]  <= '0;
        mem_b[i]  <= '0;
        mem_at[i] <= 1'b0;
        mem_bt[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_a[wr_ptr[AW-1:0]]  <= cmd_a;
        mem_b[wr_ptr[AW-1:0]]  <= cmd_b;
        mem_at[wr_ptr[AW-1:0]] <= cmd_a_t;
        mem_bt[wr_ptr[AW-1:0]] <= cmd_b_t;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Issue outputs are loaded on the IDLE->ISSUE edge so they are visible during ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_valid <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_a_t   <= 1'b0;
      mul_b_t   <= 1'b0;
    end else begin
      mul_valid <= (state_d == S_ISSUE);
      mul_a     <= (state_d == S_ISSUE) ? mem_a[rd_ptr[AW-1:0]]  : '0;
      mul_b     <= (state_d == S_ISSUE) ? mem_b[rd_ptr[AW-1:0]]  : '0;
      mul_a_t   <= (state_d == S_ISSUE) ? mem_at[rd_ptr[AW-1:0]] : 1'b0;
      mul_b_t   <= (state_d == S_ISSUE) ? mem_bt[rd_ptr[AW-1:0]] : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_data_t <= 1'b0;
      res_cycles <= '0;
      timeout    <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      timeout   <= 1'b0;
      if (state_q == S_ISSUE) begin
        cnt_q <= CNT_W'(1);
      end else if (state_q == S_WAIT) begin
        if (mul_done) begin
          res_valid  <= 1'b1;
          res_data   <= mul_result;
          res_data_t <= mul_result_t;
          res_cycles <= cnt_q;
        end else if (at_limit) begin
          timeout <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Anything whose timing follows the multiplier's done inherits a sticky timing taint.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tim_t <= 1'b0;
      wd_t  <= 1'b0;
      occ_t <= 1'b0;
    end else begin
      tim_t <= tim_t | ((state_q == S_WAIT) & mul_done_t);
      wd_t  <= (state_q == S_WAIT) & mul_done_t;
      occ_t <= occ_t | cmd_valid_t | tim_t;
    end
  end

  assign mul_valid_t  = tim_t;
  assign res_valid_t  = tim_t | wd_t;
  assign timeout_t    = tim_t | wd_t;
  assign res_cycles_t = tim_t | wd_t;
  assign cmd_ready_t  = occ_t;

endmodule

// File: tb/tb_mul_issue_ctrl_taint.sv
// Directed bench for mul_issue_ctrl_taint: vector table of single transactions plus hand-written
// sequences for FIFO fill, timeout, sticky taint and mid-wait reset.
module tb_mul_issue_ctrl_taint;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 0, cmd_valid_t = 0, cmd_a_t = 0, cmd_b_t = 0;
  logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
  logic cmd_ready, cmd_ready_t;
  logic mul_valid, mul_valid_t, mul_a_t, mul_b_t;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic mul_done = 0, mul_done_t = 0, mul_result_t = 0;
  logic [2*WIDTH-1:0] mul_result = '0;
  logic res_valid, res_valid_t, res_data_t, res_cycles_t, timeout, timeout_t;
  logic [2*WIDTH-1:0] res_data;
  logic [CNT_W-1:0] res_cycles;

  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];

  mul_issue_ctrl_taint #(.WIDTH(WIDTH), .DEPTH(4), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_valid_t(cmd_valid_t),
    .cmd_ready(cmd_ready), .cmd_ready_t(cmd_ready_t),
    .cmd_a(cmd_a), .cmd_a_t(cmd_a_t), .cmd_b(cmd_b), .cmd_b_t(cmd_b_t),
    .mul_valid(mul_valid), .mul_valid_t(mul_valid_t),
    .mul_a(mul_a), .mul_a_t(mul_a_t), .mul_b(mul_b), .mul_b_t(mul_b_t),
    .mul_done(mul_done), .mul_done_t(mul_done_t),
    .mul_result(mul_result), .mul_result_t(mul_result_t),
    .res_valid(res_valid), .res_valid_t(res_valid_t),
    .res_data(res_data), .res_data_t(res_data_t),
    .res_cycles(res_cycles), .res_cycles_t(res_cycles_t),
    .timeout(timeout), .timeout_t(timeout_t)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Issue monitor feeding the ordering scoreboard
  always @(negedge clk) if (mul_valid) got_q.push_back(mul_a);

  typedef struct {
    logic [WIDTH-1:0]   a, b;
    logic               at, bt;
    logic [2*WIDTH-1:0] prod;
    logic               prod_t;
    int                 d;
  } vec_t;
  vec_t vecs[5];

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 0; mul_done = 0; mul_done_t = 0;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic at, input logic bt);
    int n;
    cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_a_t = at; cmd_b_t = bt;
    n = 0;
    while (!cmd_ready && n < 40) begin cyc(); n++; end
    if (n >= 40) chk("push_ready_timeout", 0, 1);
    cyc();
    cmd_valid = 0; cmd_a_t = 0; cmd_b_t = 0;
  endtask

  task automatic wait_issue();
    int n;
    n = 0;
    while (!mul_valid && n < 40) begin cyc(); n++; end
    if (n >= 40) chk("issue_wait_expired", 0, 1);
  endtask

  // From the ISSUE cycle: d WAIT cycles, then done with the given product.
  task automatic complete(input int d, input logic [2*WIDTH-1:0] prod,
                          input logic prod_t, input logic done_t);
    repeat (d) cyc();
    mul_done = 1; mul_result = prod; mul_result_t = prod_t; mul_done_t = done_t;
    cyc();
    mul_done = 0; mul_result_t = 0; mul_done_t = 0;
  endtask

  initial begin
    int n;
    vecs[0] = '{a: 4'd3,  b: 4'd5,  at: 0, bt: 0, prod: 8'd15,  prod_t: 0, d: 2};
    vecs[1] = '{a: 4'd0,  b: 4'd7,  at: 1, bt: 0, prod: 8'd0,   prod_t: 1, d: 1};
    vecs[2] = '{a: 4'd15, b: 4'd15, at: 0, bt: 0, prod: 8'd225, prod_t: 0, d: 1};
    vecs[3] = '{a: 4'd2,  b: 4'd9,  at: 0, bt: 1, prod: 8'd18,  prod_t: 0, d: 5};
    vecs[4] = '{a: 4'd7,  b: 4'd6,  at: 0, bt: 0, prod: 8'd42,  prod_t: 0, d: TIMEOUT};

    do_reset();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cmd_ready_t", cmd_ready_t, 0);

    // Single transactions; last vector has done arriving on the timeout cycle itself.
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].at, vecs[i].bt);
      wait_issue();
      chk("vec_mul_a", mul_a, vecs[i].a);
      chk("vec_mul_b", mul_b, vecs[i].b);
      chk("vec_mul_a_t", mul_a_t, vecs[i].at);
      chk("vec_mul_b_t", mul_b_t, vecs[i].bt);
      complete(vecs[i].d, vecs[i].prod, vecs[i].prod_t, 0);
      chk("vec_res_valid", res_valid, 1);
      chk("vec_res_data", res_data, vecs[i].prod);
      chk("vec_res_cycles", res_cycles, vecs[i].d);
      chk("vec_res_data_t", res_data_t, vecs[i].prod_t);
      chk("vec_timeout", timeout, 0);
      chk("vec_res_valid_t", res_valid_t, 0);
      chk("vec_res_cycles_t", res_cycles_t, 0);
      chk("vec_mul_valid_t", mul_valid_t, 0);
      cyc();
      chk("vec_res_pulse", res_valid, 0);
      chk("vec_res_hold", res_data, vecs[i].prod);
      chk("vec_mul_a_idle", mul_a, 0);
    end

    // FIFO fill behind an outstanding request, then ordering check.
    do_reset();
    push(4'd9, 4'd1, 0, 0);
    wait_issue();
    cyc();
    got_q.delete();
    exp_q.delete();
    for (int k = 1; k <= 4; k++) begin
      push(4'(k), 4'd1, 0, 0);
      exp_q.push_back(4'(k));
    end
    chk("fill_ready_low", cmd_ready, 0);
    cmd_valid = 1; cmd_a = 4'd5; cmd_b = 4'd1;
    cyc();
    chk("fill_ready_held", cmd_ready, 0);
    mul_done = 1; mul_result = 8'd9;
    cyc();
    mul_done = 0;
    chk("fill_res_cycles", res_cycles, 6);
    n = 0;
    while (!cmd_ready && n < 20) begin cyc(); n++; end
    if (n >= 20) chk("fill_ready_return", 0, 1);
    cyc();
    cmd_valid = 0;
    exp_q.push_back(4'd5);
    mul_done = 1; mul_result = 8'd1;
    cyc();
    mul_done = 0;
    chk("fill_first_cycles", res_cycles, 2);
    for (int k = 0; k < 4; k++) begin
      wait_issue();
      complete(1, 8'd1, 0, 0);
    end
    chk("order_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk("order_entry", got_q.pop_front(), exp_q.pop_front());

    // Timeout: no done ever arrives for the first entry.
    do_reset();
    push(4'd1, 4'd1, 0, 0);
    push(4'd2, 4'd4, 0, 0);
    wait_issue();
    chk("to_first_a", mul_a, 1);
    n = 0;
    while (!timeout && n < 40) begin cyc(); n++; end
    chk("to_latency", n, TIMEOUT + 1);
    chk("to_res_valid", res_valid, 0);
    chk("to_res_data", res_data, 0);
    chk("to_timeout_t", timeout_t, 0);
    n = 0;
    while (!mul_valid && n < 40) begin cyc(); n++; end
    chk("to_next_gap", n, 1);
    chk("to_next_a", mul_a, 2);
    complete(3, 8'd8, 0, 0);
    chk("to_next_res", res_data, 8);
    chk("to_next_cycles", res_cycles, 3);

    // Tainted done makes timing taint sticky.
    push(4'd5, 4'd5, 0, 0);
    wait_issue();
    chk("tt_before", mul_valid_t, 0);
    complete(1, 8'd25, 0, 1);
    chk("tt_res_valid_t", res_valid_t, 1);
    chk("tt_res_cycles_t", res_cycles_t, 1);
    chk("tt_mul_valid_t", mul_valid_t, 1);
    cyc();
    chk("tt_cmd_ready_t", cmd_ready_t, 1);
    chk("tt_timeout_t", timeout_t, 1);
    push(4'd1, 4'd1, 0, 0);
    wait_issue();
    chk("tt_sticky_mul_valid_t", mul_valid_t, 1);
    complete(1, 8'd1, 0, 0);
    chk("tt_sticky_res_valid_t", res_valid_t, 1);
    chk("tt_res_before_rst", res_data, 1);

    // Asynchronous reset in the middle of WAIT, then a late done.
    push(4'd2, 4'd3, 0, 0);
    wait_issue();
    cyc();
    cyc();
    rst = 1;
    #1;
    chk("ar_res_data", res_data, 0);
    chk("ar_res_cycles", res_cycles, 0);
    chk("ar_cmd_ready_t", cmd_ready_t, 0);
    chk("ar_mul_valid_t", mul_valid_t, 0);
    chk("ar_res_valid_t", res_valid_t, 0);
    chk("ar_cmd_ready", cmd_ready, 1);
    cyc();
    rst = 0;
    mul_done = 1; mul_result = 8'd6;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("ar_late_res_valid", res_valid, 0);
      chk("ar_no_issue", mul_valid, 0);
    end
    mul_done = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=done");
    $fatal(1);
  end
endmodule
